// File: rtl/clock_set_ctrl_pkg.sv
// Shared mode encodings for the clock set controller and the display mux.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package clock_set_ctrl_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      ST_RUN   = 2'd0,
      ST_SET_H = 2'd1,
      ST_SET_M = 2'd2
   } state_e;

   // Mode button order: RUN -> SET_HOUR -> SET_MIN -> RUN.
   function automatic state_e next_mode(input state_e s);
      case (s)
         ST_RUN:   next_mode = ST_SET_H;
         ST_SET_H: next_mode = ST_SET_M;
         default:  next_mode = ST_RUN;
      endcase
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button/tick inputs and counter-control outputs of the clock set controller.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle pulses or levels.
//   master: drives tick_1hz/btn_*; slave (controller): drives the counter controls and mode.
interface clock_set_ctrl_if;

   logic                                 tick_1hz;
   logic                                 btn_mode;
   logic                                 btn_inc_p;
   logic                                 btn_inc_lvl;
   logic                                 sec_en;
   logic                                 cascade_en;
   logic                                 inc_min;
   logic                                 inc_hour;
   logic                                 sec_clr;
   logic                                 blank_h;
   logic                                 blank_m;
   logic [clock_set_ctrl_pkg::MODE_W-1:0] mode;

   modport master (
      output tick_1hz, btn_mode, btn_inc_p, btn_inc_lvl,
      input  sec_en, cascade_en, inc_min, inc_hour, sec_clr, blank_h, blank_m, mode
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc_p, btn_inc_lvl,
      output sec_en, cascade_en, inc_min, inc_hour, sec_clr, blank_h, blank_m, mode
   );

endinterface

// File: rtl/clock_set_ctrl_btn_autorepeat.sv
// Hold/auto-repeat generator: event after HOLD_CYC cycles of lvl_i held, then every REP_CYC cycles.
// Latency: combinational evt_o in the cycle the hold/repeat count completes.
// Backpressure: none; counters clear as soon as lvl_i drops.
//   ports: clk, rst (async active-low), lvl_i (debounced button level), evt_o (repeat event pulse)
module clock_set_ctrl_btn_autorepeat #(
   parameter int HOLD_CYC = 25_000_000,
   parameter int REP_CYC  = 6_250_000
)(
   input  logic clk,
   input  logic rst,
   input  logic lvl_i,
   output logic evt_o
);

   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int REP_W  = $clog2(REP_CYC + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_ARMED = HOLD_W'(HOLD_CYC);
   localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REP_CYC - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [REP_W-1:0]  rep_q, rep_d;

   // hold_q parks at HOLD_ARMED once the initial hold delay has elapsed;
   // from then on rep_q paces the repeat events.
   always_comb begin
      hold_d = hold_q;
      rep_d  = rep_q;
      evt_o  = 1'b0;
      if (!lvl_i) begin
         hold_d = '0;
         rep_d  = '0;
      end else if (hold_q == HOLD_ARMED) begin
         if (rep_q == REP_LAST) begin
            rep_d = '0;
            evt_o = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end else if (hold_q == HOLD_LAST) begin
         hold_d = HOLD_ARMED;
         rep_d  = '0;
         evt_o  = 1'b1;
      end else begin
         hold_d = hold_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
         rep_q  <= '0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-set sequencer for the HH:MM:SS clock: tick gating, field increments, blink, timeout.
// Latency: one cycle, every output is registered from the inputs of the previous edge.
// Backpressure: none; button/tick pulses are consumed the cycle they arrive.
//   ports: clk, rst (async active-low), bus (slave: tick/buttons in, counter controls + mode out)
module clock_set_ctrl
   import clock_set_ctrl_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int HOLD_DIV   = 2,
   parameter int REPEAT_DIV = 8,
   parameter int TIMEOUT_S  = 30
)(
   input  logic            clk,
   input  logic            rst,
   clock_set_ctrl_if.slave bus
);

   localparam int TMO_W = $clog2(TIMEOUT_S + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_S - 1);

   state_e            state_q, state_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              phase_q, phase_d;
   logic              inc_hour_d, inc_min_d, sec_clr_d;
   logic              sec_en_q, cascade_en_q, inc_min_q, inc_hour_q, sec_clr_q;
   logic              blank_h_q, blank_m_q;
   logic              rep_evt, inc_evt;

   clock_set_ctrl_btn_autorepeat #(
      .HOLD_CYC (CLK_HZ / HOLD_DIV),
      .REP_CYC  (CLK_HZ / REPEAT_DIV)
   ) u_autorepeat (
      .clk   (clk),
      .rst   (rst),
      .lvl_i (bus.btn_inc_lvl),
      .evt_o (rep_evt)
   );

   assign inc_evt = bus.btn_inc_p | rep_evt;

   // Priority: mode button > increment > timeout tick. A mode press drops any
   // coincident increment; an increment rescues a SET state from timing out.
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      phase_d    = bus.tick_1hz ? ~phase_q : phase_q;
      inc_hour_d = 1'b0;
      inc_min_d  = 1'b0;
      sec_clr_d  = 1'b0;
      if (bus.btn_mode) begin
         state_d   = next_mode(state_q);
         tmo_d     = '0;
         sec_clr_d = (state_q == ST_SET_M);
      end else if (state_q == ST_RUN) begin
         tmo_d = '0;
      end else if (inc_evt) begin
         inc_hour_d = (state_q == ST_SET_H);
         inc_min_d  = (state_q == ST_SET_M);
         tmo_d      = '0;
         phase_d    = 1'b1;   // show the field solid right after it changes
      end else if (bus.tick_1hz) begin
         if (tmo_q == TMO_LAST) begin
            state_d = ST_RUN;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         tmo_q        <= '0;
         phase_q      <= 1'b1;
         sec_en_q     <= 1'b0;
         cascade_en_q <= 1'b1;
         inc_min_q    <= 1'b0;
         inc_hour_q   <= 1'b0;
         sec_clr_q    <= 1'b0;
         blank_h_q    <= 1'b0;
         blank_m_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         phase_q      <= phase_d;
         sec_en_q     <= bus.tick_1hz & (state_q == ST_RUN);
         // Carries re-enable one cycle after leaving SET_MIN, so the sec_clr
         // cycle itself cannot ripple into the minute field.
         cascade_en_q <= (state_q == ST_RUN);
         inc_min_q    <= inc_min_d;
         inc_hour_q   <= inc_hour_d;
         sec_clr_q    <= sec_clr_d;
         blank_h_q    <= (state_d == ST_SET_H) & ~phase_d;
         blank_m_q    <= (state_d == ST_SET_M) & ~phase_d;
      end
   end

   assign bus.sec_en     = sec_en_q;
   assign bus.cascade_en = cascade_en_q;
   assign bus.inc_min    = inc_min_q;
   assign bus.inc_hour   = inc_hour_q;
   assign bus.sec_clr    = sec_clr_q;
   assign bus.blank_h    = blank_h_q;
   assign bus.blank_m    = blank_m_q;
   assign bus.mode       = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;
   int   cnt_sec, cnt_h, cnt_m, cnt_clr;

   clock_set_ctrl_if bus_if ();

   clock_set_ctrl #(
      .CLK_HZ     (100),
      .HOLD_DIV   (2),
      .REPEAT_DIV (10),
      .TIMEOUT_S  (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_counts();
      cnt_sec = 0;
      cnt_h   = 0;
      cnt_m   = 0;
      cnt_clr = 0;
   endtask

   // Apply one cycle of inputs, sample outputs #1 after the edge, tally pulses.
   task automatic step(input logic t, input logic m, input logic p, input logic l);
      bus_if.tick_1hz    = t;
      bus_if.btn_mode    = m;
      bus_if.btn_inc_p   = p;
      bus_if.btn_inc_lvl = l;
      @(posedge clk);
      #1;
      if (bus_if.sec_en)   cnt_sec++;
      if (bus_if.inc_hour) cnt_h++;
      if (bus_if.inc_min)  cnt_m++;
      if (bus_if.sec_clr)  cnt_clr++;
      bus_if.tick_1hz    = 1'b0;
      bus_if.btn_mode    = 1'b0;
      bus_if.btn_inc_p   = 1'b0;
      bus_if.btn_inc_lvl = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus_if.tick_1hz = 1'b0; bus_if.btn_mode = 1'b0;
      bus_if.btn_inc_p = 1'b0; bus_if.btn_inc_lvl = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus_if.mode !== 2'd0) begin n_errors++; $display("FAIL reset_mode: got %0d expected 0", bus_if.mode); end
      n_checks++;
      if (bus_if.cascade_en !== 1'b1) begin n_errors++; $display("FAIL reset_cascade: got %b expected 1", bus_if.cascade_en); end
      n_checks++;
      if ({bus_if.sec_en, bus_if.inc_hour, bus_if.inc_min, bus_if.sec_clr, bus_if.blank_h, bus_if.blank_m} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_pulses: got %b expected 000000",
                  {bus_if.sec_en, bus_if.inc_hour, bus_if.inc_min, bus_if.sec_clr, bus_if.blank_h, bus_if.blank_m});
      end
      rst = 1'b1;
      step(0, 0, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd0) begin n_errors++; $display("FAIL post_reset_mode: got %0d expected 0", bus_if.mode); end
   endtask

   task automatic test_run_ticks();
      clear_counts();
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         n_checks++;
         if (bus_if.sec_en !== 1'b1) begin n_errors++; $display("FAIL run_sec_en[%0d]: got %b expected 1", i, bus_if.sec_en); end
         step(0, 0, 0, 0);
      end
      n_checks++;
      if (cnt_sec != 3) begin n_errors++; $display("FAIL run_sec_count: got %0d expected 3", cnt_sec); end
      n_checks++;
      if (bus_if.cascade_en !== 1'b1 || bus_if.mode !== 2'd0) begin
         n_errors++; $display("FAIL run_state: cascade %b mode %0d, expected 1 and 0", bus_if.cascade_en, bus_if.mode);
      end
      n_checks++;
      if (cnt_h + cnt_m != 0) begin n_errors++; $display("FAIL run_inc: got %0d inc pulses expected 0", cnt_h + cnt_m); end
   endtask

   task automatic test_set_hour();
      clear_counts();
      step(0, 1, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd1) begin n_errors++; $display("FAIL sethour_mode: got %0d expected 1", bus_if.mode); end
      step(0, 0, 0, 0);
      n_checks++;
      if (bus_if.cascade_en !== 1'b0) begin n_errors++; $display("FAIL sethour_cascade: got %b expected 0", bus_if.cascade_en); end
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      n_checks++;
      if (cnt_h != 2 || cnt_m != 0) begin n_errors++; $display("FAIL sethour_inc: hour %0d min %0d expected 2 and 0", cnt_h, cnt_m); end
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      n_checks++;
      if (cnt_sec != 0) begin n_errors++; $display("FAIL sethour_sec_en: got %0d pulses expected 0", cnt_sec); end
      n_checks++;
      if (bus_if.mode !== 2'd1) begin n_errors++; $display("FAIL sethour_hold_mode: got %0d expected 1", bus_if.mode); end
      step(0, 1, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd2) begin n_errors++; $display("FAIL setmin_mode: got %0d expected 2", bus_if.mode); end
   endtask

   task automatic test_autorepeat();
      int   bad_pos;
      logic exp;
      clear_counts();
      bad_pos = 0;
      for (int k = 1; k <= 80; k++) begin
         step(0, 0, (k == 1), 1);
         exp = (k == 1 || k == 50 || k == 60 || k == 70 || k == 80);
         if (bus_if.inc_min !== exp) bad_pos++;
      end
      repeat (3) step(0, 0, 0, 0);
      n_checks++;
      if (bad_pos != 0) begin n_errors++; $display("FAIL repeat_timing: got %0d misplaced cycles expected 0", bad_pos); end
      n_checks++;
      if (cnt_m != 5 || cnt_h != 0) begin n_errors++; $display("FAIL repeat_count: min %0d hour %0d expected 5 and 0", cnt_m, cnt_h); end
      clear_counts();
      for (int k = 1; k <= 49; k++) step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);
      n_checks++;
      if (cnt_m != 0) begin n_errors++; $display("FAIL repeat_short_hold: got %0d inc_min expected 0", cnt_m); end
   endtask

   task automatic test_exit_set_min();
      clear_counts();
      step(0, 1, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd0 || bus_if.sec_clr !== 1'b1) begin
         n_errors++; $display("FAIL exit_mode_clr: mode %0d sec_clr %b expected 0 and 1", bus_if.mode, bus_if.sec_clr);
      end
      n_checks++;
      if (bus_if.cascade_en !== 1'b0) begin n_errors++; $display("FAIL exit_cascade_early: got %b expected 0", bus_if.cascade_en); end
      step(0, 0, 0, 0);
      n_checks++;
      if (bus_if.cascade_en !== 1'b1 || bus_if.sec_clr !== 1'b0) begin
         n_errors++; $display("FAIL exit_next: cascade %b sec_clr %b expected 1 and 0", bus_if.cascade_en, bus_if.sec_clr);
      end
      n_checks++;
      if (cnt_clr != 1) begin n_errors++; $display("FAIL exit_clr_count: got %0d expected 1", cnt_clr); end
   endtask

   task automatic test_timeout();
      clear_counts();
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      n_checks++;
      if (bus_if.inc_hour !== 1'b1 || bus_if.blank_h !== 1'b0) begin
         n_errors++; $display("FAIL tmo_inc: inc_hour %b blank_h %b expected 1 and 0", bus_if.inc_hour, bus_if.blank_h);
      end
      step(1, 0, 0, 0);
      n_checks++;
      if (bus_if.blank_h !== 1'b1 || bus_if.mode !== 2'd1) begin
         n_errors++; $display("FAIL tmo_tick1: blank_h %b mode %0d expected 1 and 1", bus_if.blank_h, bus_if.mode);
      end
      step(1, 0, 0, 0);
      n_checks++;
      if (bus_if.blank_h !== 1'b0 || bus_if.mode !== 2'd1) begin
         n_errors++; $display("FAIL tmo_tick2: blank_h %b mode %0d expected 0 and 1", bus_if.blank_h, bus_if.mode);
      end
      step(1, 0, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd0 || bus_if.blank_h !== 1'b0) begin
         n_errors++; $display("FAIL tmo_exit: mode %0d blank_h %b expected 0 and 0", bus_if.mode, bus_if.blank_h);
      end
      step(0, 0, 0, 0);
      n_checks++;
      if (cnt_clr != 0 || cnt_sec != 0) begin
         n_errors++; $display("FAIL tmo_pulses: sec_clr %0d sec_en %0d expected 0 and 0", cnt_clr, cnt_sec);
      end
   endtask

   task automatic test_timeout_vs_inc();
      clear_counts();
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      n_checks++;
      if (bus_if.inc_hour !== 1'b1 || bus_if.mode !== 2'd1) begin
         n_errors++; $display("FAIL tmo_vs_inc: inc_hour %b mode %0d expected 1 and 1", bus_if.inc_hour, bus_if.mode);
      end
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd1) begin n_errors++; $display("FAIL tmo_restart_hold: mode %0d expected 1", bus_if.mode); end
      step(1, 0, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd0) begin n_errors++; $display("FAIL tmo_restart_exit: mode %0d expected 0", bus_if.mode); end
   endtask

   task automatic test_mode_inc_same();
      clear_counts();
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      n_checks++;
      if (bus_if.mode !== 2'd2 || bus_if.inc_hour !== 1'b0 || bus_if.inc_min !== 1'b0) begin
         n_errors++; $display("FAIL mode_inc_same: mode %0d inc_hour %b inc_min %b expected 2,0,0",
                              bus_if.mode, bus_if.inc_hour, bus_if.inc_min);
      end
      step(0, 0, 1, 0);
      n_checks++;
      if (bus_if.inc_min !== 1'b1) begin n_errors++; $display("FAIL mode_inc_after: inc_min %b expected 1", bus_if.inc_min); end
   endtask

   task automatic test_reset_mid_set();
      bus_if.btn_mode  = 1'b1;
      bus_if.btn_inc_p = 1'b1;
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus_if.mode !== 2'd0 || bus_if.cascade_en !== 1'b1) begin
         n_errors++; $display("FAIL rst_mid_async: mode %0d cascade %b expected 0 and 1", bus_if.mode, bus_if.cascade_en);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus_if.inc_min !== 1'b0 || bus_if.sec_clr !== 1'b0 || bus_if.blank_m !== 1'b0) begin
         n_errors++; $display("FAIL rst_mid_pulses: inc_min %b sec_clr %b blank_m %b expected 0,0,0",
                              bus_if.inc_min, bus_if.sec_clr, bus_if.blank_m);
      end
      bus_if.btn_mode  = 1'b0;
      bus_if.btn_inc_p = 1'b0;
      rst = 1'b1;
      step(0, 0, 0, 0);
      n_checks++;
      if (bus_if.mode !== 2'd0) begin n_errors++; $display("FAIL rst_mid_after: mode %0d expected 0", bus_if.mode); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      clear_counts();
      test_reset();
      test_run_ticks();
      test_set_hour();
      test_autorepeat();
      test_exit_set_min();
      test_timeout();
      test_timeout_vs_inc();
      test_mode_inc_same();
      test_reset_mid_set();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
